// File: rtl/idli_pkg.sv
// Shared core types: datapath slice/counter types, IO pin limits and GPIO op encoding.
package idli_pkg;

   typedef logic [1:0] ctr_t;
   typedef logic [3:0] slice_t;

   localparam int unsigned NUM_IO_PINS   = 4;
   localparam int unsigned GPIO_MAX_PINS = 16;

   typedef enum logic [2:0] {
      GPIO_OP_NONE    = 3'd0,
      GPIO_OP_RD_IN   = 3'd1,
      GPIO_OP_RD_OUT  = 3'd2,
      GPIO_OP_RD_EDGE = 3'd3,
      GPIO_OP_WR      = 3'd4,
      GPIO_OP_SET     = 3'd5,
      GPIO_OP_CLR     = 3'd6,
      GPIO_OP_TGL     = 3'd7
   } gpio_op_t;

   function automatic logic gpio_op_is_rd(gpio_op_t op);
      return op inside {GPIO_OP_RD_IN, GPIO_OP_RD_OUT, GPIO_OP_RD_EDGE};
   endfunction

endpackage

// File: rtl/idli_sync_m.sv
// Multi-stage per-bit input synchroniser with asynchronous active-low reset.
module idli_sync_m #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= i_d;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign o_q = stage_q[STAGES-1];

endmodule

// File: rtl/idli_gpio_m.sv
// GPIO unit on the 4b slice datapath: synchronised inputs, registered outputs, bitwise ops.
// Optional sticky rising-edge capture is enabled by defining IDLI_GPIO_EDGE_EN.
module idli_gpio_m
   import idli_pkg::*;
#(
   parameter int unsigned NUM_PINS    = NUM_IO_PINS,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  ctr_t                i_gpio_ctr,
   input  logic                i_gpio_vld,
   input  gpio_op_t            i_gpio_op,
   input  slice_t              i_gpio_data,
   output slice_t              o_gpio_data,
   input  logic [NUM_PINS-1:0] i_gpio_pins,
   output logic [NUM_PINS-1:0] o_gpio_pins,
   output logic                o_gpio_edge
);

   typedef logic [NUM_PINS-1:0] pins_t;

   pins_t       pins_sync;
   pins_t       out_q;
   pins_t       snap_q;
   pins_t       flags;
   pins_t       src;
   pins_t       d_pins;
   logic [11:0] opnd_q;
   logic [15:0] d_word;
   logic [15:0] rd_word;
   gpio_op_t    op_q;
   gpio_op_t    cur_op;

   idli_sync_m #(
      .WIDTH  (NUM_PINS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_gpio_pins),
      .o_q     (pins_sync)
   );

   // At ctr 0 the op is taken live from the request so slice 0 needs no extra cycle.
   always_comb begin
      cur_op = op_q;
      if (i_gpio_ctr == 2'd0) begin
         cur_op = i_gpio_vld ? i_gpio_op : GPIO_OP_NONE;
      end
   end

   always_comb begin
      src = '0;
      case (cur_op)
         GPIO_OP_RD_IN:   src = pins_sync;
         GPIO_OP_RD_OUT:  src = out_q;
         GPIO_OP_RD_EDGE: src = flags;
         default:         src = '0;
      endcase
   end

   always_comb begin
      rd_word     = (i_gpio_ctr == 2'd0) ? 16'(src) : 16'(snap_q);
      o_gpio_data = '0;
      if (gpio_op_is_rd(cur_op)) begin
         o_gpio_data = rd_word[{i_gpio_ctr, 2'b00} +: 4];
      end
   end

   assign d_word = {i_gpio_data, opnd_q};
   assign d_pins = pins_t'(d_word);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q   <= GPIO_OP_NONE;
         opnd_q <= '0;
         snap_q <= '0;
         out_q  <= '0;
      end else begin
         case (i_gpio_ctr)
            2'd0: begin
               op_q   <= cur_op;
               snap_q <= src;
               opnd_q <= {i_gpio_data, opnd_q[11:4]};
            end
            2'd1, 2'd2: begin
               opnd_q <= {i_gpio_data, opnd_q[11:4]};
            end
            default: begin
               op_q <= GPIO_OP_NONE;
               case (op_q)
                  GPIO_OP_WR:  out_q <= d_pins;
                  GPIO_OP_SET: out_q <= out_q | d_pins;
                  GPIO_OP_CLR: out_q <= out_q & ~d_pins;
                  GPIO_OP_TGL: out_q <= out_q ^ d_pins;
                  default:     out_q <= out_q;
               endcase
            end
         endcase
      end
   end

   assign o_gpio_pins = out_q;

`ifdef IDLI_GPIO_EDGE_EN
   pins_t sync_prev_q;
   pins_t flag_q;
   pins_t edge_new;
   pins_t flag_clr;

   // Only flags captured in the read snapshot are cleared; a fresh edge always wins.
   assign edge_new = pins_sync & ~sync_prev_q;
   assign flag_clr = ((i_gpio_ctr == 2'd3) && (op_q == GPIO_OP_RD_EDGE)) ? snap_q : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_prev_q <= '0;
         flag_q      <= '0;
      end else begin
         sync_prev_q <= pins_sync;
         flag_q      <= (flag_q & ~flag_clr) | edge_new;
      end
   end

   assign flags       = flag_q;
   assign o_gpio_edge = |flag_q;
`else
   assign flags       = '0;
   assign o_gpio_edge = 1'b0;
`endif

endmodule

// File: doc/idli_gpio_m.md
# idli_gpio_m

Parametrised general-purpose IO unit that replaces the fixed four-in/four-out pin handling of the core. It synchronises external inputs, drives a registered output bank, and supports read, write and bitwise set/clear/toggle operations. It also provides sticky rising-edge capture. All accesses move over the core's 4b slice datapath, one slice per cycle across one four-cycle instruction, and the unit sits beside the ALU/shifter as the `PIPE_IO` result source.

## Interface
- `NUM_PINS`, default 4: number of input and of output pins, range 1..16.
- `SYNC_STAGES`, default 2: depth of the input synchroniser chain, range 2..4.

Ports:
- `i_clk` in 1: core clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_gpio_ctr` in `ctr_t`: slice counter, 0..3, free-running with the core.
- `i_gpio_vld` in 1: operation request, honoured only when `i_gpio_ctr == 0`.
- `i_gpio_op` in `gpio_op_t`: operation, sampled with `i_gpio_vld`.
- `i_gpio_data` in `slice_t`: operand slice `ctr` (slice 0 = bits 3:0).
- `o_gpio_data` out `slice_t`: result slice `ctr`.
- `i_gpio_pins` in `NUM_PINS`: asynchronous external inputs.
- `o_gpio_pins` out `NUM_PINS`: registered external outputs.
- `o_gpio_edge` out 1: OR of all sticky edge flags.

## Operation
Operations (`gpio_op_t`, 3b): `NONE`, `RD_IN`, `RD_OUT`, `RD_EDGE`, `WR`, `SET`, `CLR`, `TGL`.

- **Op latch:** an op is accepted when `i_gpio_vld` is high at ctr 0. It is held in an op register for ctr 1..3 and returns to `NONE` after ctr 3. `i_gpio_vld` at ctr 1..3 is ignored.
- **Operands:** 16b operand assembled LSB slice first in a 12b shift register (slices 0..2). Slice 3 is used live at ctr 3. Operand bits at or above `NUM_PINS` are ignored.
- **Reads:**
  - Source: synchronised inputs, output register, or edge flags.
  - Zero-extended to 16b.
  - Source snapshot taken at ctr 0. Slice 0 is driven combinationally from the live source. Slices 1..3 come from the snapshot, so all four slices are coherent.
  - `o_gpio_data` is 0 when the current op is `NONE` or a write-class op.
- **Write commit** at the ctr 3 clock edge, on the 16b operand `D`:
  - `WR`: out = D.
  - `SET`: out |= D.
  - `CLR`: out &= ~D.
  - `TGL`: out ^= D.
- **Edge capture:** flag[i] sets on a 0->1 transition between the last two synchroniser stages of pin i.
  - `RD_EDGE` clears, at its ctr 3 edge, exactly the flags that were set in its snapshot.
  - A new edge in the same cycle as the clear wins: the flag stays set.
- **Reset:** asynchronous. Clears outputs, synchronisers, flags, snapshot, operand and op register, and `o_gpio_data` reads 0. Reset mid-operation abandons the op with no commit. After release, the first op is accepted at the next ctr 0.

## Timing
- Reset values: `o_gpio_pins` = 0, `o_gpio_data` = 0, `o_gpio_edge` = 0.
- Input latency: pin change to visible in `RD_IN` = `SYNC_STAGES` edges.
- Edge flag and `o_gpio_edge`: high `SYNC_STAGES`+1 edges after the pin rises.
- Write latency: `o_gpio_pins` changes on the clock edge ending the ctr 3 cycle of the op.
- Read latency: slice k valid in the ctr k cycle (zero cycles, combinational from state).
- Back-to-back ops: an op at ctr 0 immediately after a write sees the committed value for `RD_OUT`.
- Throughput: one op per four cycles, no stalls, no backpressure.

## Configuration
- `IDLI_GPIO_EDGE_EN`
  - Defined: edge flags, `RD_EDGE` and `o_gpio_edge` are implemented as above.
  - Undefined: no flag registers. `RD_EDGE` returns 0 and clears nothing, and `o_gpio_edge` is tied to 0.

## Structure
- Shared package additions:
  - `gpio_op_t`.
  - `GPIO_MAX_PINS = 16`.
  - `NUM_IO_PINS` retained as the default for `NUM_PINS`.
- Sub-module `idli_sync_m`: per-bit `SYNC_STAGES`-deep synchroniser with async active-low reset. It is instantiated once with width `NUM_PINS`.

## Test plan
- **Write and bitwise ops** (`NUM_PINS` = 4):
  - `WR` 0x0005 -> `o_gpio_pins` = 4'b0101 after the ctr 3 edge.
  - `SET` 0x000A -> 4'b1111.
  - `CLR` 0x0003 -> 4'b1100.
  - `TGL` 0xFFFF -> 4'b0011; upper operand bits have no effect.
- **Input read:** drive pins 4'b1001, wait 2 cycles, `RD_IN` -> slices 9, 0, 0, 0. Pins changing to 4'b0110 during ctr 1..3 do not alter slices 1..3.
- **Wide config** (`NUM_PINS` = 13): `WR` 0xFFFF then `RD_OUT` -> slices F, F, F, 1.
- **Edge capture:**
  - Pulse pin 2 -> `o_gpio_edge` = 1 three edges later.
  - `RD_EDGE` -> slice 0 = 4, flag cleared.
  - A pin 0 edge landing on the clear cycle survives; the next `RD_EDGE` returns 1.
- **Reset mid-op:** assert `i_rst_n` low at ctr 2 of `WR` 0x000F -> pins stay 0 and `o_gpio_data` = 0. After release, `vld` at ctr 2 is ignored and an op at the next ctr 0 executes.
- **Config off:** without `IDLI_GPIO_EDGE_EN`, pulse pins then `RD_EDGE` -> all slices 0, and `o_gpio_edge` is never 1.
